// File: rtl/cop_seq_pkg.sv
// Shared types for the coprocessor-request sequencer.
//   cop_seq_entry_t : one stored command (insn, three operands, expects-response flag)
//   cop_seq_state_e : replay FSM states
package cop_seq_pkg;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned REG_W      = 64;
    localparam int unsigned RESP_CNT_W = 16;

    typedef struct packed {
        logic [INST_W-1:0] insn;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rs3;
        logic              exp_resp;
    } cop_seq_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } cop_seq_state_e;

endpackage

// File: rtl/cop_seq_cmd_store.sv
// Command store: DEPTH x cop_seq_entry_t register file, one write port, one async read port.
//   clk, rst_n     : clock, async active-low reset (entries cleared)
//   we/waddr/wdata : write port
//   raddr/rdata    : combinational read port
module cop_seq_cmd_store
    import cop_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  cop_seq_entry_t             wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output cop_seq_entry_t             rdata
);

    cop_seq_entry_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cop_req_sequencer.sv
// Coprocessor-request player: loads up to DEPTH commands, replays them on the cop req channel
// with a programmable gap and at most MAX_OUTSTD unanswered expect-response commands.
//   ld_*            : command load handshake (accepted in IDLE only)
//   start_i, clr_i  : start replay (IDLE/DONE), clear store and status (any state)
//   gap_i           : idle cycles between request handshakes
//   cpu_tpu_req_*   : request channel out; cpu_tpu_resp_* : response channel in
//   busy_o, done_o, err_o, timeout_o, resp_cnt_o, last_resp_o : status
// Optional watchdog: define COP_SEQ_TIMEOUT_EN to abort ISSUE/DRAIN stalls after TIMEOUT_CYC.
module cop_req_sequencer
    import cop_seq_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned MAX_OUTSTD  = 4,
    parameter int unsigned GAP_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_vld_i,
    output logic                  ld_rdy_o,
    input  logic [INST_W-1:0]     ld_insn_i,
    input  logic [REG_W-1:0]      ld_rs1_i,
    input  logic [REG_W-1:0]      ld_rs2_i,
    input  logic [REG_W-1:0]      ld_rs3_i,
    input  logic                  ld_exp_resp_i,
    input  logic                  start_i,
    input  logic                  clr_i,
    input  logic [GAP_W-1:0]      gap_i,
    output logic                  cpu_tpu_req_vld_o,
    input  logic                  cpu_tpu_req_rdy_i,
    output logic [INST_W-1:0]     cpu_tpu_req_insn_o,
    output logic [REG_W-1:0]      cpu_tpu_req_rs1_data_o,
    output logic [REG_W-1:0]      cpu_tpu_req_rs2_data_o,
    output logic [REG_W-1:0]      cpu_tpu_req_rs3_data_o,
    input  logic                  cpu_tpu_resp_vld_i,
    output logic                  cpu_tpu_resp_rdy_o,
    input  logic [REG_W-1:0]      cpu_tpu_resp_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  timeout_o,
    output logic [RESP_CNT_W-1:0] resp_cnt_o,
    output logic [REG_W-1:0]      last_resp_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTD + 1);

    cop_seq_state_e state;
    logic [CW-1:0]    count, count_inc, rd_ptr, rd_ptr_nxt;
    logic [OW-1:0]    outstd, outstd_nxt;
    logic [GAP_W-1:0] gap_cnt;
    cop_seq_entry_t   ld_entry, rd_data, rd_fwd, req_pld;
    logic start_acc, ld_acc, hsk, resp_acc, issue_inc, resp_err, issue_ok_nxt, wd_fire;

    assign cpu_tpu_resp_rdy_o     = 1'b1;
    assign cpu_tpu_req_insn_o     = req_pld.insn;
    assign cpu_tpu_req_rs1_data_o = req_pld.rs1;
    assign cpu_tpu_req_rs2_data_o = req_pld.rs2;
    assign cpu_tpu_req_rs3_data_o = req_pld.rs3;

    // Handshake qualifiers and next-cycle datapath values shared by FSM and status logic.
    always_comb begin
        ld_entry.insn     = ld_insn_i;
        ld_entry.rs1      = ld_rs1_i;
        ld_entry.rs2      = ld_rs2_i;
        ld_entry.rs3      = ld_rs3_i;
        ld_entry.exp_resp = ld_exp_resp_i;
        start_acc = start_i && !clr_i && (state == ST_IDLE || state == ST_DONE);
        ld_acc    = ld_vld_i && ld_rdy_o && !clr_i;
        count_inc = count + CW'(ld_acc);
        hsk       = (state == ST_ISSUE) && cpu_tpu_req_vld_o && cpu_tpu_req_rdy_i;
        resp_acc  = cpu_tpu_resp_vld_i;
        issue_inc = hsk && req_pld.exp_resp;
        // A response in the same cycle as an expect-response issue pairs with it.
        resp_err  = resp_acc && (outstd == '0) && !issue_inc;

        rd_ptr_nxt = rd_ptr;
        if (clr_i || start_acc) rd_ptr_nxt = '0;
        else if (hsk)           rd_ptr_nxt = rd_ptr + CW'(1);

        outstd_nxt = outstd;
        if (clr_i || start_acc)                          outstd_nxt = '0;
        else if (issue_inc && !resp_acc)                 outstd_nxt = outstd + OW'(1);
        else if (!issue_inc && resp_acc && outstd != '0) outstd_nxt = outstd - OW'(1);

        // Forward a load landing on the entry about to be presented (start with load same cycle).
        rd_fwd = (ld_acc && count[AW-1:0] == rd_ptr_nxt[AW-1:0]) ? ld_entry : rd_data;
        issue_ok_nxt = !(rd_fwd.exp_resp && outstd_nxt == OW'(MAX_OUTSTD));
    end

    cop_seq_cmd_store #(.DEPTH(DEPTH)) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ld_acc),
        .waddr (count[AW-1:0]),
        .wdata (ld_entry),
        .raddr (rd_ptr_nxt[AW-1:0]),
        .rdata (rd_data)
    );

    // Replay FSM with registered handshake and status-level outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE; count <= '0; gap_cnt <= '0;
            cpu_tpu_req_vld_o <= 1'b0; ld_rdy_o <= 1'b1; busy_o <= 1'b0; done_o <= 1'b0;
        end else if (clr_i) begin
            state <= ST_IDLE; count <= '0; gap_cnt <= '0;
            cpu_tpu_req_vld_o <= 1'b0; ld_rdy_o <= 1'b1; busy_o <= 1'b0; done_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    count <= count_inc;
                    if (start_i) begin
                        ld_rdy_o <= 1'b0;
                        if (count_inc == '0) begin
                            state <= ST_DONE; busy_o <= 1'b0; done_o <= 1'b1;
                            cpu_tpu_req_vld_o <= 1'b0;
                        end else begin
                            state <= ST_ISSUE; busy_o <= 1'b1; done_o <= 1'b0;
                            cpu_tpu_req_vld_o <= issue_ok_nxt;
                        end
                    end else if (state == ST_IDLE) begin
                        ld_rdy_o <= (count_inc < CW'(DEPTH));
                    end
                end
                ST_ISSUE: begin
                    if (wd_fire) begin
                        state <= ST_DONE; cpu_tpu_req_vld_o <= 1'b0;
                        busy_o <= 1'b0; done_o <= 1'b1;
                    end else if (hsk && rd_ptr_nxt == count) begin
                        state <= ST_DRAIN; cpu_tpu_req_vld_o <= 1'b0;
                    end else if (hsk && gap_i != '0) begin
                        state <= ST_GAP; gap_cnt <= gap_i; cpu_tpu_req_vld_o <= 1'b0;
                    end else begin
                        cpu_tpu_req_vld_o <= issue_ok_nxt;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state <= ST_ISSUE; cpu_tpu_req_vld_o <= issue_ok_nxt;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (wd_fire || outstd == '0) begin
                        state <= ST_DONE; busy_o <= 1'b0; done_o <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read pointer, outstanding count, presented payload and response status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0; outstd <= '0; req_pld <= '0;
            resp_cnt_o <= '0; err_o <= 1'b0; last_resp_o <= '0;
        end else begin
            rd_ptr  <= rd_ptr_nxt;
            outstd  <= outstd_nxt;
            req_pld <= rd_fwd;
            if (clr_i) begin
                resp_cnt_o <= '0; err_o <= 1'b0; last_resp_o <= '0;
            end else begin
                if (start_acc) begin
                    resp_cnt_o <= '0; err_o <= 1'b0;
                end
                if (resp_acc) begin
                    last_resp_o <= cpu_tpu_resp_data_i;
                    if (start_acc)               resp_cnt_o <= RESP_CNT_W'(1);
                    else if (resp_cnt_o != '1)   resp_cnt_o <= resp_cnt_o + RESP_CNT_W'(1);
                    if (resp_err)                err_o <= 1'b1;
                end
            end
        end
    end

`ifdef COP_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            stall;

    // Stall = request offered but not taken, or draining with no response this cycle.
    assign stall   = (state == ST_ISSUE && cpu_tpu_req_vld_o && !cpu_tpu_req_rdy_i) ||
                     (state == ST_DRAIN && !resp_acc);
    assign wd_fire = stall && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0; timeout_o <= 1'b0;
        end else if (clr_i) begin
            wd_cnt <= '0; timeout_o <= 1'b0;
        end else begin
            wd_cnt <= (stall && !wd_fire) ? wd_cnt + WD_W'(1) : '0;
            if (wd_fire)        timeout_o <= 1'b1;
            else if (start_acc) timeout_o <= 1'b0;
        end
    end
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cop_req_sequencer.sv
// Directed bench for cop_req_sequencer: a model store of loaded commands is pushed into an
// expected queue at each start, and every request handshake pops and compares one entry.
module tb_cop_req_sequencer;
    import cop_seq_pkg::*;

    localparam int unsigned DEPTH = 16, MAX_OUTSTD = 4, GAP_W = 8, TIMEOUT_CYC = 64;

    logic clk, rst_n;
    logic ld_vld, ld_rdy, ld_exp_resp, start, clr;
    logic [INST_W-1:0] ld_insn, req_insn;
    logic [REG_W-1:0]  ld_rs1, ld_rs2, ld_rs3, req_rs1, req_rs2, req_rs3, resp_data, last_resp;
    logic [GAP_W-1:0]  gap;
    logic req_vld, req_rdy, resp_vld, resp_rdy, busy, done, err, timeout;
    logic [RESP_CNT_W-1:0] resp_cnt;

    int n_pass = 0, n_chk = 0, cyc = 0;
    cop_seq_entry_t model[$], exp_q[$];
    int hs_edge[$];

    cop_req_sequencer #(.DEPTH(DEPTH), .MAX_OUTSTD(MAX_OUTSTD), .GAP_W(GAP_W),
                        .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_vld_i(ld_vld), .ld_rdy_o(ld_rdy), .ld_insn_i(ld_insn),
        .ld_rs1_i(ld_rs1), .ld_rs2_i(ld_rs2), .ld_rs3_i(ld_rs3), .ld_exp_resp_i(ld_exp_resp),
        .start_i(start), .clr_i(clr), .gap_i(gap),
        .cpu_tpu_req_vld_o(req_vld), .cpu_tpu_req_rdy_i(req_rdy), .cpu_tpu_req_insn_o(req_insn),
        .cpu_tpu_req_rs1_data_o(req_rs1), .cpu_tpu_req_rs2_data_o(req_rs2),
        .cpu_tpu_req_rs3_data_o(req_rs3),
        .cpu_tpu_resp_vld_i(resp_vld), .cpu_tpu_resp_rdy_o(resp_rdy),
        .cpu_tpu_resp_data_i(resp_data),
        .busy_o(busy), .done_o(done), .err_o(err), .timeout_o(timeout),
        .resp_cnt_o(resp_cnt), .last_resp_o(last_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [223:0] obs, input logic [223:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Scoreboard: each handshake (taken on the next rising edge) pops one expected command.
    always @(negedge clk) begin
        if (rst_n && req_vld && req_rdy) begin
            cop_seq_entry_t e;
            hs_edge.push_back(cyc + 1);
            check("hsk_expected", 224'(exp_q.size() > 0), 224'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hsk_payload", {req_insn, req_rs1, req_rs2, req_rs3},
                      {e.insn, e.rs1, e.rs2, e.rs3});
            end
        end
    end

    function automatic cop_seq_entry_t mk(input int t, input int i, input logic er);
        cop_seq_entry_t e;
        e.insn     = {8'hC0, 8'(t), 16'(i)};
        e.rs1      = {$urandom(), $urandom()};
        e.rs2      = {$urandom(), $urandom()};
        e.rs3      = {$urandom(), $urandom()};
        e.exp_resp = er;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input cop_seq_entry_t e);
        ld_vld = 1'b1; ld_insn = e.insn; ld_rs1 = e.rs1; ld_rs2 = e.rs2; ld_rs3 = e.rs3;
        ld_exp_resp = e.exp_resp;
        if (model.size() < DEPTH) model.push_back(e);
        tick(1);
        ld_vld = 1'b0;
    endtask

    task automatic do_start();
        foreach (model[i]) exp_q.push_back(model[i]);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        model.delete(); exp_q.delete(); hs_edge.delete();
    endtask

    task automatic send_resp(input logic [REG_W-1:0] d);
        resp_vld = 1'b1; resp_data = d;
        tick(1);
        resp_vld = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin tick(1); k++; end
        check("done_reached", 224'(done), 224'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [223:0] held;
        int k, t_done;
        cop_seq_entry_t extra;
        rst_n = 1'b0; ld_vld = 0; ld_insn = '0; ld_rs1 = '0; ld_rs2 = '0; ld_rs3 = '0;
        ld_exp_resp = 0; start = 0; clr = 0; gap = '0; req_rdy = 0; resp_vld = 0; resp_data = '0;
        tick(3);
        check("rst_flags", {ld_rdy, resp_rdy, req_vld, busy, done, err, timeout}, 224'(7'b1100000));
        rst_n = 1'b1;
        tick(1);
        check("rst_resp_cnt", 224'(resp_cnt), 224'(0));
        check("rst_last_resp", 224'(last_resp), 224'(0));
        check("rst_req_insn", 224'(req_insn), 224'(0));

        // 1: back-to-back replay of four commands
        req_rdy = 1'b1; gap = '0;
        for (int i = 0; i < 4; i++) load(mk(1, i, 1'b0));
        do_start();
        wait_done(50);
        t_done = cyc;
        check("t1_hsk_count", 224'(hs_edge.size()), 224'(4));
        if (hs_edge.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("t1_back_to_back", 224'(hs_edge[i] - hs_edge[i-1]), 224'(1));
            check("t1_done_latency", 224'(t_done - hs_edge[3]), 224'(1));
        end
        check("t1_resp_cnt", 224'(resp_cnt), 224'(0));
        check("t1_busy", 224'(busy), 224'(0));

        // 2: gap of 10 cycles, with a 5-cycle ready stall on the second request
        do_clr();
        gap = 8'd10;
        for (int i = 0; i < 3; i++) load(mk(2, i, 1'b0));
        do_start();
        k = 0;
        while (hs_edge.size() < 1 && k < 20) begin tick(1); k++; end
        k = 0;
        while (req_vld !== 1'b1 && k < 30) begin tick(1); k++; end
        check("t2_vld_after_gap", 224'(req_vld), 224'(1));
        held = {req_insn, req_rs1, req_rs2, req_rs3};
        req_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_vld_hold", 224'(req_vld), 224'(1));
            check("t2_payload_hold", {req_insn, req_rs1, req_rs2, req_rs3}, held);
            tick(1);
        end
        req_rdy = 1'b1;
        wait_done(60);
        check("t2_hsk_count", 224'(hs_edge.size()), 224'(3));
        if (hs_edge.size() == 3) begin
            check("t2_gap_with_stall", 224'(hs_edge[1] - hs_edge[0]), 224'(16));
            check("t2_gap_exact", 224'(hs_edge[2] - hs_edge[1]), 224'(11));
        end

        // 3: outstanding limit with withheld responses
        do_clr();
        gap = '0;
        for (int i = 0; i < 6; i++) load(mk(3, i, 1'b1));
        do_start();
        tick(12);
        check("t3_hsk_at_limit", 224'(hs_edge.size()), 224'(4));
        check("t3_vld_blocked", 224'(req_vld), 224'(0));
        check("t3_busy", 224'(busy), 224'(1));
        send_resp(64'hDEAD);
        tick(3);
        check("t3_fifth_issued", 224'(hs_edge.size()), 224'(5));
        check("t3_vld_blocked_again", 224'(req_vld), 224'(0));
        check("t3_last_dead", 224'(last_resp), 224'(64'hDEAD));
        check("t3_resp_cnt1", 224'(resp_cnt), 224'(1));
        for (int i = 0; i < 5; i++) send_resp(64'h1000 + 64'(i));
        wait_done(20);
        check("t3_hsk_count", 224'(hs_edge.size()), 224'(6));
        check("t3_resp_cnt", 224'(resp_cnt), 224'(6));
        check("t3_last_resp", 224'(last_resp), 224'(64'h1004));
        check("t3_no_err", 224'(err), 224'(0));

        // 4: full store, rejected 17th load, replayed twice
        do_clr();
        for (int i = 0; i < 16; i++) load(mk(4, i, 1'b0));
        check("t4_full_rdy", 224'(ld_rdy), 224'(0));
        extra = mk(4, 16, 1'b0);
        ld_vld = 1'b1; ld_insn = extra.insn; ld_rs1 = extra.rs1; ld_rs2 = extra.rs2;
        ld_rs3 = extra.rs3; ld_exp_resp = 1'b0;
        tick(2);
        check("t4_full_rdy_held", 224'(ld_rdy), 224'(0));
        ld_vld = 1'b0;
        do_start();
        wait_done(60);
        check("t4_first_count", 224'(hs_edge.size()), 224'(16));
        hs_edge.delete();
        do_start();
        check("t4_restart_clears_done", 224'(done), 224'(0));
        wait_done(60);
        check("t4_second_count", 224'(hs_edge.size()), 224'(16));
        check("t4_queue_drained", 224'(exp_q.size()), 224'(0));

        // 5: unexpected response while idle, then clear
        do_clr();
        send_resp(64'hBEEF);
        check("t5_err", 224'(err), 224'(1));
        check("t5_resp_cnt", 224'(resp_cnt), 224'(1));
        check("t5_last_resp", 224'(last_resp), 224'(64'hBEEF));
        do_clr();
        check("t5_clr_status", {err, done, busy, ld_rdy}, 224'(4'b0001));
        check("t5_clr_resp_cnt", 224'(resp_cnt), 224'(0));
        check("t5_clr_last_resp", 224'(last_resp), 224'(0));
        do_start();
        check("t5_empty_done", {done, busy}, 224'(2'b10));
        check("t5_empty_no_hsk", 224'(hs_edge.size()), 224'(0));

        // 6: asynchronous reset in the middle of a stalled replay
        do_clr();
        req_rdy = 1'b0;
        for (int i = 0; i < 3; i++) load(mk(6, i, 1'b0));
        do_start();
        tick(3);
        check("t6_vld_before_rst", 224'(req_vld), 224'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_flags", {ld_rdy, resp_rdy, req_vld, busy, done, err, timeout},
              224'(7'b1100000));
        check("t6_rst_insn", 224'(req_insn), 224'(0));
        tick(1);
        rst_n = 1'b1;
        model.delete(); exp_q.delete(); hs_edge.delete();
        tick(1);
        check("t6_after_rst", {req_vld, done, ld_rdy}, 224'(3'b001));

`ifdef COP_SEQ_TIMEOUT_EN
        // watchdog fires on the 64th stalled cycle
        for (int i = 0; i < 2; i++) load(mk(7, i, 1'b0));
        do_start();
        tick(63);
        check("t6_pre_timeout", {timeout, req_vld}, 224'(2'b01));
        tick(1);
        check("t6_timeout", {timeout, req_vld, done, busy}, 224'(4'b1010));
        do_clr();
`endif
        req_rdy = 1'b1;
        tick(2);
        check("final_queue_empty", 224'(exp_q.size()), 224'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
